// File: rtl/line_buf_ctrl_pkg.sv
// Shared ISP line-buffer package: line-state enum, default line length and
// a ring-index helper used by the line buffer controller.
package line_buf_ctrl_pkg;

    localparam int unsigned LINE_LENGTH_DEFAULT = 640;
    localparam int unsigned RING_IDX_WIDTH      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } line_state_t;

    // Advance a ring line index, wrapping at depth.
    function automatic logic [RING_IDX_WIDTH-1:0] ring_inc(
        input logic [RING_IDX_WIDTH-1:0] idx,
        input int unsigned               depth
    );
        if (32'(idx) + 32'd1 >= depth) begin
            return '0;
        end
        return idx + RING_IDX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/line_buf_rd_seq.sv
// Read-side scanner: walks one buffered line two pixels per word.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clr           drop the current line (frame restart or overflow abort)
//   start         request a new line; honoured only when idle
//   rd_active     a line is being scanned
//   rd_addr       word address within the line
//   rd_odd        second pixel of the current word
//   rd_end_c      combinational: this cycle is the last pixel of the line
module line_buf_rd_seq
    import line_buf_ctrl_pkg::*;
#(
    parameter int unsigned LINE_LENGTH = LINE_LENGTH_DEFAULT,
    parameter int unsigned CNT_WIDTH   = $clog2(LINE_LENGTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 start,
    output logic                 rd_active,
    output logic [CNT_WIDTH-1:0] rd_addr,
    output logic                 rd_odd,
    output logic                 rd_end_c
);

    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(LINE_LENGTH - 1);

    assign rd_end_c = rd_active && rd_odd && (rd_addr == LAST_ADDR);

    // Scan state; a clear or line end always returns to idle before any restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_active <= 1'b0;
            rd_addr   <= '0;
            rd_odd    <= 1'b0;
        end else if (clr || rd_end_c) begin
            rd_active <= 1'b0;
            rd_addr   <= '0;
            rd_odd    <= 1'b0;
        end else if (rd_active) begin
            rd_odd <= ~rd_odd;
            if (rd_odd) begin
                rd_addr <= rd_addr + CNT_WIDTH'(1);
            end
        end else if (start) begin
            rd_active <= 1'b1;
            rd_addr   <= '0;
            rd_odd    <= 1'b0;
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Line buffer controller: tracks sensor line writes into a ring of line
// memories and schedules debayer read lines once enough lines are buffered.
// Optional build macro: LINE_BUF_CTRL_OVF_STAT_EN adds a 16-bit saturating
// overflow counter output (ovf_cnt), cleared only by rst_n.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   frame_start   synchronous frame restart pulse (highest priority)
//   in_valid      one input word this cycle
//   wr_en         write strobe (combinational from in_valid)
//   wr_line       ring line being written
//   wr_addr       word address within the write line
//   rd_active     read line in progress
//   rd_addr       read word address
//   rd_odd        second pixel of the read word
//   rd_base       oldest line of the 3-line window
//   pix_valid     rd_active delayed by the 2-cycle datapath
//   ovf           one-cycle pulse: line completed into a full ring
//   ovf_cnt       (macro only) saturating overflow count
module line_buf_ctrl
    import line_buf_ctrl_pkg::*;
#(
    parameter  int unsigned LINE_LENGTH = LINE_LENGTH_DEFAULT,
    parameter  int unsigned NUM_LINES   = 4,
    parameter  int unsigned FILL_THRESH = 3,
    localparam int unsigned CNT_WIDTH   = $clog2(LINE_LENGTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 in_valid,
    output logic                 wr_en,
    output logic [1:0]           wr_line,
    output logic [CNT_WIDTH-1:0] wr_addr,
    output logic                 rd_active,
    output logic [CNT_WIDTH-1:0] rd_addr,
    output logic                 rd_odd,
    output logic [1:0]           rd_base,
    output logic                 pix_valid,
    output logic                 ovf
`ifdef LINE_BUF_CTRL_OVF_STAT_EN
    ,
    output logic [15:0]          ovf_cnt
`endif
);

    localparam int unsigned AVAIL_WIDTH = $clog2(NUM_LINES + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(LINE_LENGTH - 1);

    line_state_t            state, state_nxt;
    logic [AVAIL_WIDTH-1:0] lines_avail, avail_nxt;
    logic                   wr_fire, wr_done, rd_end, ovf_evt, rd_start, rd_clr;
    logic                   pix_d1;

    // A word arriving with frame_start is discarded, so it is never written.
    assign wr_fire = in_valid && !frame_start;
    assign wr_en   = wr_fire && rst_n;
    assign wr_done = wr_fire && (wr_addr == LAST_ADDR);

    // Fill-level bookkeeping; a full ring drops its oldest line instead of growing.
    always_comb begin
        avail_nxt = lines_avail;
        ovf_evt   = 1'b0;
        if (wr_done && !rd_end) begin
            if (lines_avail == AVAIL_WIDTH'(NUM_LINES)) begin
                ovf_evt = 1'b1;
            end else begin
                avail_nxt = lines_avail + AVAIL_WIDTH'(1);
            end
        end else if (rd_end && !wr_done) begin
            if (lines_avail != '0) begin
                avail_nxt = lines_avail - AVAIL_WIDTH'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (wr_fire) state_nxt = PRIME;
                PRIME:   if (32'(avail_nxt) >= FILL_THRESH) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start uses post-update fill so a read can begin the cycle after the filling write.
    assign rd_start = (state_nxt == RUN) && (32'(avail_nxt) >= FILL_THRESH);
    assign rd_clr   = frame_start || ovf_evt;

    line_buf_rd_seq #(
        .LINE_LENGTH (LINE_LENGTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_rd_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (rd_clr),
        .start     (rd_start),
        .rd_active (rd_active),
        .rd_addr   (rd_addr),
        .rd_odd    (rd_odd),
        .rd_end_c  (rd_end)
    );

    // Write pointer, ring pointers, fill level and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            wr_line     <= '0;
            rd_base     <= '0;
            lines_avail <= '0;
            ovf         <= 1'b0;
        end else if (frame_start) begin
            wr_addr     <= '0;
            wr_line     <= '0;
            rd_base     <= '0;
            lines_avail <= '0;
            ovf         <= 1'b0;
        end else begin
            ovf         <= ovf_evt;
            lines_avail <= avail_nxt;
            if (wr_fire) begin
                wr_addr <= wr_done ? '0 : wr_addr + CNT_WIDTH'(1);
            end
            if (wr_done) begin
                wr_line <= ring_inc(wr_line, NUM_LINES);
            end
            if (rd_end || ovf_evt) begin
                rd_base <= ring_inc(rd_base, NUM_LINES);
            end
        end
    end

    // Memory read stage plus debayer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_d1    <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            pix_d1    <= rd_active;
            pix_valid <= pix_d1;
        end
    end

`ifdef LINE_BUF_CTRL_OVF_STAT_EN
    // Saturating overflow statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (ovf_evt && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 Parameter LINE_LENGTH, default 640, meaning words per sensor line (each word carries two 12-bit pixels).
REQ-002 Parameter NUM_LINES, default 4, meaning line-buffer ring depth in lines.
REQ-003 Parameter FILL_THRESH, default 3, meaning completed lines required before a read line starts.
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, named rst_n.
REQ-005 clk  input  1  rising-edge clock for all logic.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 frame_start  input  1  single-cycle pulse, synchronous frame restart.
REQ-008 in_valid  input  1  one input word this cycle.
REQ-009 wr_en  output  1  write strobe to the line memories.
REQ-010 wr_line  output  2  ring line selected for writing.
REQ-011 wr_addr  output  CNT_WIDTH  word address within the write line; CNT_WIDTH = $clog2(LINE_LENGTH).
REQ-012 rd_active  output  1  a read line is being scanned.
REQ-013 rd_addr  output  CNT_WIDTH  word address for the read side.
REQ-014 rd_odd  output  1  selects the second pixel of the current word.
REQ-015 rd_base  output  2  oldest ring line of the 3-line debayer window.
REQ-016 pix_valid  output  1  debayered pixel valid at the datapath output.
REQ-017 ovf  output  1  one-cycle pulse when a line completes while the ring is full.

Function
REQ-018 wr_en SHALL equal in_valid combinationally; wr_addr SHALL increment on each wr_en and wrap from LINE_LENGTH-1 to 0.
REQ-019 On the wr_en that writes address LINE_LENGTH-1: wr_line advances mod NUM_LINES; lines_avail (internal, 0..NUM_LINES) increments.
REQ-020 FSM states: IDLE, PRIME, RUN; IDLE->PRIME on the first in_valid; PRIME->RUN when lines_avail >= FILL_THRESH.
REQ-021 In RUN with rd_active=0 and lines_avail >= FILL_THRESH, rd_active SHALL assert on the next cycle with rd_addr=0 and rd_odd=0.
REQ-022 While rd_active: rd_odd toggles every cycle; rd_addr increments when rd_odd=1; each line takes exactly 2*LINE_LENGTH cycles.
REQ-023 The cycle with rd_odd=1 and rd_addr=LINE_LENGTH-1 ends the line: rd_active deasserts; rd_base advances mod NUM_LINES; lines_avail decrements.
REQ-024 Read end and write completion in the same cycle: lines_avail SHALL be unchanged.
REQ-025 Write completion with lines_avail=NUM_LINES and no read end: ovf pulses; lines_avail is held; rd_base advances, dropping the oldest line; an active read line is aborted (rd_active=0).
REQ-026 pix_valid SHALL equal rd_active delayed by exactly 2 cycles (memory read plus debayer register).
REQ-027 frame_start SHALL, on the next edge, zero wr_addr, wr_line, rd_addr, rd_base, rd_odd, rd_active and lines_avail and force IDLE, with priority over all other events in that cycle, including an in_valid in the same cycle, which is discarded.
REQ-028 lines_avail arithmetic SHALL be unsigned and saturating at 0 and NUM_LINES; no wrap.

Reset
REQ-029 While rst_n=0, all outputs SHALL be 0 and the FSM SHALL be IDLE; pix_valid is 0 during reset and for 2 cycles after release.
REQ-030 Reset asserted mid-line SHALL abandon the line; no partial state survives.

Configuration
REQ-031 With LINE_BUF_CTRL_OVF_STAT_EN defined: add output ovf_cnt (16 bits), saturating at 16'hFFFF and incremented on each ovf, cleared only by rst_n.
REQ-032 Without LINE_BUF_CTRL_OVF_STAT_EN: no ovf_cnt port or counter; ovf pulse unchanged.

Structure
REQ-033 The shared ISP package SHALL hold the line-state enum (IDLE/PRIME/RUN) and the LINE_LENGTH default constant.
REQ-034 One sub-module, line_buf_rd_seq, SHALL contain the read scanner (rd_addr/rd_odd/rd_active and the end-of-line pulse); all else is top-level.

Verification (LINE_LENGTH=8 unless stated)
REQ-035 Continuous in_valid from reset: wr_line sequence 0,1,2,3,0 every 8 valid cycles; rd_active first asserts 1 cycle after the 24th write.
REQ-036 Steady state with in_valid 50% duty: read lines each span exactly 16 cycles; rd_addr goes 0,0,1,1..7,7; pix_valid trails rd_active by 2.
REQ-037 Simultaneous read end and write completion at lines_avail=3: lines_avail stays 3; rd_base and wr_line both advance.
REQ-038 in_valid=1 for 40 words with no read progress (FILL_THRESH=5, so reads never start): ovf pulses once, at word 40; rd_base=1; with the macro defined, ovf_cnt=1.
REQ-039 frame_start during word 5 of line 2: next cycle wr_addr=0, wr_line=0, rd_active=0, FSM IDLE; the next full 3 lines restart the sequence.
REQ-040 rst_n pulsed low mid-read: outputs 0 asynchronously; pix_valid stays 0 for 2 cycles after release.
